// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the word-copy bus master: FSM states and default widths.
package mem_copy_master_pkg;

  localparam int unsigned DEF_W  = 32;
  localparam int unsigned DEF_AW = 24;
  localparam int unsigned DEF_LW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_master.sv
// Copies len W-bit words from src to dst over a simple sel/write/ready bus,
// alternating one read and one write per word in ascending address order.
module mem_copy_master
  import mem_copy_master_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr,
  output logic [W-1:0]  wdata,
  output logic          write,
  output logic          sel,
  input  logic [W-1:0]  rdata,
  input  logic          ready
);

  localparam int unsigned   BYTES  = W / 8;
  localparam logic [AW-1:0] STRIDE = AW'(BYTES);

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;

  logic          busy_d, done_d, sel_d, write_d;
  logic [AW-1:0] addr_d;
  logic [W-1:0]  wdata_d;
  logic          rdy_c;

  // Only a clean logic 1 counts as ready; 0/x/z all stall the bus phase.
  assign rdy_c = (ready == 1'b1);

  // State, pointers, buffer and bus outputs; outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sel     <= 1'b0;
      write   <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy    <= busy_d;
      done    <= done_d;
      sel     <= sel_d;
      write   <= write_d;
      addr    <= addr_d;
      wdata   <= wdata_d;
    end
  end

  // Next-state, datapath updates and the bus view of the upcoming state.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sel_d   = 1'b0;
    write_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            cnt_d   = len;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD: begin
        if (rdy_c) begin
          data_d  = rdata;
          state_d = WR;
        end
      end
      WR: begin
        if (rdy_c) begin
          cnt_d   = cnt_q - LW'(1);
          src_d   = src_q + STRIDE;
          dst_d   = dst_q + STRIDE;
          state_d = (cnt_q != LW'(1)) ? RD : DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Held phases recompute identical values, so a stalled write repeats unchanged.
    case (state_d)
      RD: begin
        busy_d = 1'b1;
        sel_d  = 1'b1;
        addr_d = src_d;
      end
      WR: begin
        busy_d  = 1'b1;
        sel_d   = 1'b1;
        write_d = 1'b1;
        addr_d  = dst_d;
        wdata_d = data_d;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: word-level memory model with scripted and random ready.
module tb_mem_copy_master;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 8;
  localparam int unsigned BYTES = W / 8;

  logic          clk = 1'b0;
  logic          rst_n, start, ready;
  logic [AW-1:0] src, dst, addr;
  logic [LW-1:0] len;
  logic          busy, done, write, sel;
  logic [W-1:0]  wdata, rdata;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem     [logic [AW-1:0]];
  logic [W-1:0] exp_mem [logic [AW-1:0]];
  logic         rp[$];
  logic [W-1:0] vals[$];

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    int            n;
    int            stall;
    logic [W-1:0]  w0;
    logic [W-1:0]  w1;
    int            poke;
    int            exp_done;
  } vec_t;

  mem_copy_master #(.W(W), .AW(AW), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .addr  (addr),
    .wdata (wdata),
    .write (write),
    .sel   (sel),
    .rdata (rdata),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [W-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return '0;
  endfunction

  // One clock: responder samples the bus mid-cycle, memory commits on the edge when write was high.
  task automatic step();
    logic          w;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    @(negedge clk);
    w = write;
    a = addr;
    d = wdata;
    rdata = (sel === 1'b1 && write === 1'b0) ? mem_rd(a) : '0;
    @(posedge clk);
    if (w === 1'b1) mem[a] = d;
    #1;
  endtask

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                          input int stall, input bit rnd, input int poke, output int obs_done);
    int p;
    int dc;
    rp.delete();
    rp.push_back(1'b1);
    for (int ph = 0; ph < 2 * n; ph++) begin
      if (rnd) begin
        while ($urandom_range(0, 9) < 3) rp.push_back(1'b0);
      end else begin
        repeat (stall) rp.push_back(1'b0);
      end
      rp.push_back(1'b1);
    end
    repeat (4) rp.push_back(1'b1);

    // Reference: sequential ascending word copy on a snapshot of memory.
    exp_mem = mem;
    vals.delete();
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] v;
      v = exp_rd(AW'(s + BYTES * k));
      vals.push_back(v);
      exp_mem[AW'(d + BYTES * k)] = v;
    end

    // Each bus phase ends on a ready cycle; done follows the last of the 2n phases.
    p  = 0;
    dc = 1;
    while (p < 2 * n) begin
      if (rp[dc]) p++;
      dc++;
    end

    src   = s;
    dst   = d;
    len   = LW'(n);
    start = 1'b1;
    step();
    start = 1'b0;

    obs_done = -1;
    p = 0;
    for (int c = 1; c <= dc; c++) begin
      bit act = (c < dc);
      bit is_wr = (p % 2 == 1);
      int k = p / 2;
      logic [AW-1:0] ea;
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      ea = !act ? '0 : (is_wr ? AW'(d + BYTES * k) : AW'(s + BYTES * k));
      chk($sformatf("c%0d busy", c), 64'(busy), 64'(act));
      chk($sformatf("c%0d done", c), 64'(done), 64'(c == dc));
      chk($sformatf("c%0d sel", c), 64'(sel), 64'(act));
      chk($sformatf("c%0d write", c), 64'(write), 64'(act && is_wr));
      chk($sformatf("c%0d addr", c), 64'(addr), 64'(ea));
      if (!act) chk($sformatf("c%0d wdata idle", c), 64'(wdata), 64'(0));
      else if (is_wr) chk($sformatf("c%0d wdata", c), 64'(wdata), 64'(vals[k]));
      if (c == poke) begin
        start = 1'b1;
        src   = ~s;
        dst   = ~d;
        len   = LW'(n + 3);
      end
      ready = rp[c];
      if (rp[c]) p++;
      step();
      start = 1'b0;
    end
    ready = 1'b1;
    chk("post busy", 64'(busy), 64'(0));
    chk("post done", 64'(done), 64'(0));
    chk("post sel", 64'(sel), 64'(0));
    foreach (exp_mem[a]) chk($sformatf("mem[%0h]", a), 64'(mem_rd(a)), 64'(exp_mem[a]));
    chk("mem size", 64'(mem.num()), 64'(exp_mem.num()));
  endtask

  initial begin
    vec_t vecs[7];
    int   od;

    vecs[0] = '{s: 24'h000004, d: 24'h000040, n: 2,   stall: 0, w0: 32'h76,       w1: 32'h04,       poke: 2, exp_done: 5};
    vecs[1] = '{s: 24'h000080, d: 24'h000090, n: 0,   stall: 0, w0: 32'h11,       w1: 32'h22,       poke: 0, exp_done: 1};
    vecs[2] = '{s: 24'h000010, d: 24'h000050, n: 1,   stall: 3, w0: 32'hDEADBEEF, w1: 32'h0,        poke: 0, exp_done: 9};
    vecs[3] = '{s: 24'hFFFFFC, d: 24'h000060, n: 2,   stall: 0, w0: 32'hA5A5A5A5, w1: 32'h5A5A5A5A, poke: 0, exp_done: 5};
    vecs[4] = '{s: 24'h000020, d: 24'h000024, n: 3,   stall: 0, w0: 32'h1,        w1: 32'h2,        poke: 0, exp_done: 7};
    vecs[5] = '{s: 24'h000400, d: 24'h000800, n: 255, stall: 0, w0: 32'h7,        w1: 32'h8,        poke: 0, exp_done: 511};
    vecs[6] = '{s: 24'h000030, d: 24'h000070, n: 2,   stall: 1, w0: 32'hC0FFEE,   w1: 32'hBEEF,     poke: 3, exp_done: 9};

    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    rdata = '0;
    src   = '0;
    dst   = '0;
    len   = '0;
    step();
    step();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst sel", 64'(sel), 64'(0));
    chk("rst write", 64'(write), 64'(0));
    chk("rst addr", 64'(addr), 64'(0));
    chk("rst wdata", 64'(wdata), 64'(0));
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      mem.delete();
      mem[vecs[i].s] = vecs[i].w0;
      mem[AW'(vecs[i].s + BYTES)] = vecs[i].w1;
      for (int k = 2; k < vecs[i].n; k++) mem[AW'(vecs[i].s + BYTES * k)] = W'($urandom);
      run_copy(vecs[i].s, vecs[i].d, vecs[i].n, vecs[i].stall, 1'b0, vecs[i].poke, od);
      chk($sformatf("vec%0d done cycle", i), 64'(od), 64'(vecs[i].exp_done));
      if (vecs[i].n > 0) chk($sformatf("vec%0d first word", i), 64'(mem_rd(vecs[i].d)), 64'(vecs[i].w0));
    end

    // Reset during the second write of a four-word copy.
    mem.delete();
    for (int k = 0; k < 4; k++) mem[AW'(24'h200 + BYTES * k)] = 32'h1000 + W'(k);
    ready = 1'b1;
    src   = 24'h200;
    dst   = 24'h300;
    len   = LW'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre-rst write", 64'(write), 64'(1));
    chk("pre-rst addr", 64'(addr), 64'(24'h304));
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", 64'(busy), 64'(0));
    chk("mid-rst sel", 64'(sel), 64'(0));
    chk("mid-rst write", 64'(write), 64'(0));
    chk("mid-rst addr", 64'(addr), 64'(0));
    chk("mid-rst wdata", 64'(wdata), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("after-rst busy", 64'(busy), 64'(0));
    chk("after-rst sel", 64'(sel), 64'(0));
    chk("after-rst done", 64'(done), 64'(0));
    chk("rst word0", 64'(mem_rd(24'h300)), 64'(32'h1000));
    chk("rst word1 absent", 64'(mem.exists(24'h304)), 64'(0));

    // Random copies with random ready stalls and overlapping windows.
    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] s, d;
      int n;
      mem.delete();
      for (int k = 0; k < 32; k++) mem[AW'(24'h100 + BYTES * k)] = W'($urandom);
      s = AW'(24'h100 + BYTES * $urandom_range(0, 15));
      d = AW'(24'h100 + BYTES * $urandom_range(0, 15));
      n = int'($urandom_range(0, 8));
      run_copy(s, d, n, 0, 1'b1, int'($urandom_range(1, 6)), od);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter W, default 32, bus data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 24, byte address width.
REQ-003 SHALL have parameter LW, default 16, word-count width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle copy request, sampled when idle.
REQ-007 SHALL have port src  input  AW  source byte address, sampled with start.
REQ-008 SHALL have port dst  input  AW  destination byte address, sampled with start.
REQ-009 SHALL have port len  input  LW  number of W-bit words to copy, sampled with start.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a copy completes.
REQ-012 SHALL have port addr  output  AW  bus byte address.
REQ-013 SHALL have port wdata  output  W  bus write data.
REQ-014 SHALL have port write  output  1  bus write strobe; the memory commits on any clock edge where it is high.
REQ-015 SHALL have port sel  output  1  bus select.
REQ-016 SHALL have port rdata  input  W  bus read data, valid while sel=1 and write=0.
REQ-017 SHALL have port ready  input  1  bus ready; any value other than logic 1 (0, x, z) is not-ready.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-019 In IDLE, start=1 with len!=0 SHALL latch src, dst and len, and move to RD.
REQ-020 In IDLE, start=1 with len=0 SHALL move to DONE with no bus activity.
REQ-021 start while not IDLE SHALL be ignored.
REQ-022 In RD, outputs SHALL be sel=1, write=0, addr=current source pointer.
REQ-023 In RD, on an edge with ready=1, rdata SHALL be captured into a W-bit buffer and the FSM SHALL move to WR.
REQ-024 In RD with ready not 1, the FSM SHALL hold RD with outputs unchanged.
REQ-025 In WR, outputs SHALL be sel=1, write=1, addr=current destination pointer, wdata=buffer.
REQ-026 In WR, on an edge with ready=1: remaining count -1, src +W/8, dst +W/8; move to RD if the remaining count after decrement is nonzero, else to DONE.
REQ-027 In WR with ready not 1, the FSM SHALL hold WR with outputs stable, so the write repeats harmlessly.
REQ-028 write SHALL be 0 in every state except WR, and SHALL be driven glitch-free from a register or state decode.
REQ-029 In IDLE and DONE, outputs SHALL be sel=0, write=0, addr=0, wdata=0.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 busy SHALL be 1 exactly in RD and WR.
REQ-032 Address increments SHALL wrap modulo 2^AW.
REQ-033 Count arithmetic SHALL be LW bits; len=2^LW-1 SHALL be supported.
REQ-034 Best-case throughput SHALL be 2 cycles per word (ready tied 1); a len=N copy SHALL assert done 2N+1 cycles after the start edge.
REQ-035 Overlapping src/dst ranges SHALL be copied in ascending address order with no hazard checking.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sel=0, write=0, addr=0, wdata=0, and clear the buffer and counters.
REQ-037 Reset asserted mid-copy SHALL abort the copy with no further write strobe; words already written remain.

Structure
REQ-038 A shared package SHALL hold the state enum (IDLE/RD/WR/DONE) and the default W/AW/LW constants.
REQ-039 The block SHALL be a single module with no sub-modules; the bus responder is external.

Verification
REQ-040 Preload 0x4=0x76 and 0x8=0x04, ready=1, start src=0x4 dst=0x40 len=2 -> 0x40=0x76, 0x44=0x04, done at cycle 5, busy for 4 cycles.
REQ-041 start with len=0 -> done the next cycle, sel never 1, memory unchanged.
REQ-042 ready held 0 for 3 cycles in RD and again in WR, len=1 -> outputs stable while waiting, a single correct word written, done at cycle 9.
REQ-043 src=0xFFFFFC, len=2 -> second read at addr 0x000000 (wrap).
REQ-044 rst_n pulsed low during the second WR of a len=4 copy -> outputs 0 at once, only the first word written, IDLE after release.
REQ-045 start pulsed while busy -> ignored, original copy completes unchanged.
